reg_wb_arbiter: RTL and testbench
=================================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3: the number of consecutive A-wins while B is pending before B is forced to win.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port ena, input, 1: global enable; 0 freezes all state.
REQ-005 SHALL have port a_valid, input, 1: write request from the main pipeline (requester A).
REQ-006 SHALL have port a_addr, input, 5: destination register for A.
REQ-007 SHALL have port a_data, input, 32: write data for A.
REQ-008 SHALL have port a_ready, output, 1: A is accepted this cycle (combinational).
REQ-009 SHALL have ports b_valid (input, 1), b_addr (input, 5), b_data (input, 32) and b_ready (output, 1): requester B, the long-latency mul/div/load unit.
REQ-010 SHALL have ports rf_write_ena (output, 1), rf_rd_addr (output, 5) and rf_rd (output, 32), which drive the regfile write port.
REQ-011 SHALL have ports rs_addr and rt_addr (input, 5 each): hazard-query addresses.
REQ-012 SHALL have ports busy_rs and busy_rt (output, 1 each) and fwd_rs and fwd_rt (output, 32 each): pending-write hit flags and forwarded data.

Function
REQ-013 SHALL hold requester B in a 2-entry FIFO; b_ready = ena && (registered count < 2); B enqueues on b_valid && b_ready.
REQ-014 SHALL never bypass the FIFO for B: a B request accepted in cycle N is eligible for grant no earlier than cycle N+1.
REQ-015 SHALL grant at most one write per cycle, selected from A (a_valid) and the FIFO head (count > 0).
REQ-016 SHALL give A priority by default.
REQ-017 SHALL give the FIFO head priority when starve_cnt == STARVE_MAX.
REQ-018 SHALL assert a_ready = ena && a_valid && A granted; A is never buffered.
REQ-019 SHALL register the grant so that a grant in cycle N produces rf_write_ena=1, rf_rd_addr and rf_rd in cycle N+1 only; rf_write_ena=0 in every other cycle.
REQ-020 SHALL consume any request with addr==0 (A via a_ready, B via dequeue) without asserting rf_write_ena.
REQ-021 SHALL use starve_cnt as follows: increment when FIFO non-empty and A granted, saturating at STARVE_MAX; clear when the FIFO head is granted or the FIFO is empty.
REQ-022 SHALL allow enqueue and dequeue in the same cycle, with count unchanged; b_ready is never asserted when count == 2, even if a dequeue occurs that cycle.
REQ-023 SHALL keep FIFO order strictly first-in first-out, with pointers wrapping modulo 2.
REQ-024 SHALL, when ena=0, force a_ready=0 and b_ready=0, issue no grant (rf_write_ena=0 next cycle), and hold FIFO, pointers and starve_cnt.
REQ-025 SHALL assert busy_rs when rs_addr != 0 and rs_addr matches any valid FIFO entry or the output stage while rf_write_ena=1; busy_rt likewise for rt_addr.
REQ-026 SHALL select forwarded data from the matching source with priority FIFO tail > FIFO head > output stage; fwd_* = 0 when not busy.
REQ-027 SHALL compute busy_*/fwd_* combinationally from current state and be independent of ena.
REQ-028 SHALL NOT order writes to the same destination; requesters guarantee that no two in-flight writes target the same register, and REQ-026 defines the result if this is violated.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, set FIFO count, pointers and starve_cnt to 0 and rf_write_ena, rf_rd_addr and rf_rd to 0.
REQ-030 SHALL, with the FIFO empty during and after reset, drive a_ready=0, b_ready=0, busy_*=0 and fwd_*=0 while rst=1.
REQ-031 SHALL let reset override ena and any in-progress request; FIFO contents are discarded.

Verification
REQ-032 SHALL cover: A only, a_addr=5, a_data=0x1234 in cycle N -> a_ready=1 in N; rf_write_ena=1, rf_rd_addr=5, rf_rd=0x1234 in N+1.
REQ-033 SHALL cover: B accepts addr=8, data=0xAA in N with A idle -> grant in N+1, rf write in N+2; busy_rs=1 with fwd_rs=0xAA for rs_addr=8 in N+1 and N+2.
REQ-034 SHALL cover: B fills the FIFO (2 entries) while A is valid every cycle -> b_ready=0; after 3 A-wins, the FIFO head writes on the 4th grant; order is preserved.
REQ-035 SHALL cover: a_addr=0 with a_valid=1 -> a_ready=1, rf_write_ena stays 0; b_addr=0 dequeues with no write.
REQ-036 SHALL cover: ena=0 for 3 cycles with both requesters valid and FIFO holding 1 entry -> no handshakes and no writes; state resumes unchanged when ena=1.
REQ-037 SHALL cover: rst=1 asserted with 2 FIFO entries and a pending output write -> the next cycle shows rf_write_ena=0, b_ready=0, busy_*=0, and b_ready=1 after rst drops.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Register-file write-back arbiter: requester A (main pipeline) wins by default, while
// requester B is buffered in a 2-entry FIFO with starvation protection and hazard lookup.
module reg_wb_arbiter #(
   parameter int STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic        a_valid,
   input  logic [4:0]  a_addr,
   input  logic [31:0] a_data,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [4:0]  b_addr,
   input  logic [31:0] b_data,
   output logic        b_ready,
   output logic        rf_write_ena,
   output logic [4:0]  rf_rd_addr,
   output logic [31:0] rf_rd,
   input  logic [4:0]  rs_addr,
   input  logic [4:0]  rt_addr,
   output logic        busy_rs,
   output logic        busy_rt,
   output logic [31:0] fwd_rs,
   output logic [31:0] fwd_rt
);
   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic [4:0]    fifo_addr_q [2];
   logic [4:0]    fifo_addr_d [2];
   logic [31:0]   fifo_data_q [2];
   logic [31:0]   fifo_data_d [2];
   logic          wr_ptr_q, wr_ptr_d;
   logic          rd_ptr_q, rd_ptr_d;
   logic [1:0]    count_q, count_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          out_we_q, out_we_d;
   logic [4:0]    out_addr_q, out_addr_d;
   logic [31:0]   out_data_q, out_data_d;

   logic live, head_avail, head_win, a_win, enq;

   // Hit search order: newest FIFO entry, then oldest, then the registered output stage.
   function automatic logic [32:0] lookup(input logic [4:0] qa);
      logic [32:0] r;
      r = '0;
      if (!rst && qa != 5'd0) begin
         if (count_q != 2'd0 && fifo_addr_q[~wr_ptr_q] == qa)
            r = {1'b1, fifo_data_q[~wr_ptr_q]};
         else if (count_q == 2'd2 && fifo_addr_q[rd_ptr_q] == qa)
            r = {1'b1, fifo_data_q[rd_ptr_q]};
         else if (out_we_q && out_addr_q == qa)
            r = {1'b1, out_data_q};
      end
      return r;
   endfunction

   always_comb begin
      live       = ena && !rst;
      head_avail = count_q != 2'd0;
      head_win   = live && head_avail && (!a_valid || starve_q == STARVE_LIM);
      a_win      = live && a_valid && !head_win;
      b_ready    = live && (count_q != 2'd2);
      a_ready    = a_win;
      enq        = b_valid && b_ready;

      fifo_addr_d = fifo_addr_q;
      fifo_data_d = fifo_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      starve_d    = starve_q;
      out_we_d    = 1'b0;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;

      // Register-zero writes are consumed but never reach the regfile port.
      if (a_win) begin
         if (a_addr != 5'd0) begin
            out_we_d   = 1'b1;
            out_addr_d = a_addr;
            out_data_d = a_data;
         end
      end else if (head_win) begin
         if (fifo_addr_q[rd_ptr_q] != 5'd0) begin
            out_we_d   = 1'b1;
            out_addr_d = fifo_addr_q[rd_ptr_q];
            out_data_d = fifo_data_q[rd_ptr_q];
         end
      end

      if (live) begin
         if (!head_avail || head_win)
            starve_d = '0;
         else if (a_win && starve_q != STARVE_LIM)
            starve_d = starve_q + 1'b1;
      end

      if (enq) begin
         fifo_addr_d[wr_ptr_q] = b_addr;
         fifo_data_d[wr_ptr_q] = b_data;
         wr_ptr_d              = ~wr_ptr_q;
      end
      if (head_win)
         rd_ptr_d = ~rd_ptr_q;

      case ({enq, head_win})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
      if (rst) begin
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         starve_q   <= '0;
         out_we_q   <= 1'b0;
         out_addr_q <= 5'd0;
         out_data_q <= 32'd0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         starve_q   <= starve_d;
         out_we_q   <= out_we_d;
         out_addr_q <= out_addr_d;
         out_data_q <= out_data_d;
      end
   end

   assign rf_write_ena     = out_we_q;
   assign rf_rd_addr       = out_addr_q;
   assign rf_rd            = out_data_q;
   assign {busy_rs, fwd_rs} = lookup(rs_addr);
   assign {busy_rt, fwd_rt} = lookup(rt_addr);

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_reg_wb_arbiter;
   localparam int STARVE_MAX = 3;

   logic        clk = 1'b0;
   logic        rst, ena;
   logic        a_valid, b_valid;
   logic [4:0]  a_addr, b_addr, rs_addr, rt_addr;
   logic [31:0] a_data, b_data;
   logic        a_ready, b_ready, rf_write_ena, busy_rs, busy_rt;
   logic [4:0]  rf_rd_addr;
   logic [31:0] rf_rd, fwd_rs, fwd_rt;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } ent_t;

   ent_t        q[$];
   int          starve = 0;
   logic        m_we = 1'b0;
   logic [4:0]  m_addr = 5'd0;
   logic [31:0] m_data = 32'd0;

   always #5 clk = ~clk;

   reg_wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst), .ena(ena),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
      .rf_write_ena(rf_write_ena), .rf_rd_addr(rf_rd_addr), .rf_rd(rf_rd),
      .rs_addr(rs_addr), .rt_addr(rt_addr),
      .busy_rs(busy_rs), .busy_rt(busy_rt), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Newest pending write wins: scan the queue from its back, then the output register.
   task automatic lookup(input logic [4:0] a, output logic bsy, output logic [31:0] d);
      bsy = 1'b0;
      d   = 32'd0;
      if (!rst && a != 5'd0) begin
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (!bsy && q[i].addr == a) begin
               bsy = 1'b1;
               d   = q[i].data;
            end
         end
         if (!bsy && m_we && m_addr == a) begin
            bsy = 1'b1;
            d   = m_data;
         end
      end
   endtask

   task automatic step(input logic e, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic [4:0] rs, input logic [4:0] rt);
      logic live, hw, exp_ar, exp_br, bsy;
      logic [31:0] fw;
      ent_t h;
      ena = e; a_valid = av; a_addr = aa; a_data = ad;
      b_valid = bv; b_addr = ba; b_data = bd; rs_addr = rs; rt_addr = rt;
      #1;
      live   = e && !rst;
      exp_br = live && q.size() < 2;
      hw     = live && q.size() > 0 && (!av || starve == STARVE_MAX);
      exp_ar = live && av && !hw;
      chk("a_ready", 32'(a_ready), 32'(exp_ar));
      chk("b_ready", 32'(b_ready), 32'(exp_br));
      chk("rf_write_ena", 32'(rf_write_ena), 32'(m_we));
      if (m_we) begin
         chk("rf_rd_addr", 32'(rf_rd_addr), 32'(m_addr));
         chk("rf_rd", rf_rd, m_data);
      end
      lookup(rs, bsy, fw);
      chk("busy_rs", 32'(busy_rs), 32'(bsy));
      chk("fwd_rs", fwd_rs, fw);
      lookup(rt, bsy, fw);
      chk("busy_rt", 32'(busy_rt), 32'(bsy));
      chk("fwd_rt", fwd_rt, fw);
      @(posedge clk);
      if (rst) begin
         q.delete();
         starve = 0;
         m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
      end else if (!e) begin
         m_we = 1'b0;
      end else begin
         m_we = 1'b0;
         if (hw) begin
            h = q.pop_front();
            starve = 0;
            if (h.addr != 5'd0) begin
               m_we = 1'b1; m_addr = h.addr; m_data = h.data;
            end
         end else if (exp_ar) begin
            if (aa != 5'd0) begin
               m_we = 1'b1; m_addr = aa; m_data = ad;
            end
            starve = (q.size() == 0) ? 0 : ((starve >= STARVE_MAX) ? STARVE_MAX : starve + 1);
         end else begin
            starve = 0;
         end
         if (exp_br && bv) q.push_back('{addr: ba, data: bd});
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rs, rt);
   endtask

   initial begin
      rst = 1'b1; ena = 1'b0;
      a_valid = 1'b0; a_addr = 5'd0; a_data = 32'd0;
      b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
      rs_addr = 5'd0; rt_addr = 5'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rf_rd_addr", 32'(rf_rd_addr), 32'd0);
      chk("rst_rf_rd", rf_rd, 32'd0);
      step(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 5'd3, 5'd4);
      rst = 1'b0;

      // A alone: accepted now, written next cycle
      step(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
      chk("a_only_we", 32'(rf_write_ena), 32'd1);
      chk("a_only_addr", 32'(rf_rd_addr), 32'd5);
      chk("a_only_data", rf_rd, 32'h1234);
      idle(5'd0, 5'd0);

      // B alone: FIFO then output stage, visible to hazard lookup throughout
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hAA, 5'd8, 5'd0);
      chk("b_fifo_busy", 32'(busy_rs), 32'd1);
      chk("b_fifo_fwd", fwd_rs, 32'hAA);
      idle(5'd8, 5'd0);
      chk("b_out_we", 32'(rf_write_ena), 32'd1);
      chk("b_out_addr", 32'(rf_rd_addr), 32'd8);
      idle(5'd8, 5'd8);

      // A every cycle while B fills the FIFO: starvation release and ordering
      for (int i = 0; i < 10; i++)
         step(1'b1, 1'b1, 5'(10 + i), 32'(100 + i), i < 4, 5'(20 + i), 32'(200 + i),
              5'(20 + (i % 3)), 5'(10 + i));
      repeat (4) idle(5'd21, 5'd22);

      // Register-zero requests consumed without writes
      step(1'b1, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      chk("a_zero_no_we", 32'(rf_write_ena), 32'd0);
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBEEF, 5'd0, 5'd0);
      repeat (3) idle(5'd0, 5'd0);

      // Enable low with one FIFO entry and both requesters pending
      step(1'b1, 1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77, 5'd7, 5'd6);
      repeat (3) step(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd11, 32'hBB, 5'd7, 5'd11);
      repeat (4) step(1'b1, 1'b1, 5'd12, 32'hCC, 1'b0, 5'd0, 32'd0, 5'd7, 5'd12);
      repeat (3) idle(5'd7, 5'd12);

      // Reset with a full FIFO and an output write in flight
      step(1'b1, 1'b1, 5'd13, 32'hD1, 1'b1, 5'd14, 32'hE1, 5'd14, 5'd13);
      step(1'b1, 1'b1, 5'd15, 32'hD2, 1'b1, 5'd16, 32'hE2, 5'd16, 5'd15);
      rst = 1'b1;
      step(1'b1, 1'b1, 5'd17, 32'hD3, 1'b1, 5'd18, 32'hE3, 5'd14, 5'd16);
      chk("rst_we_off", 32'(rf_write_ena), 32'd0);
      step(1'b1, 1'b1, 5'd17, 32'hD3, 1'b1, 5'd18, 32'hE3, 5'd14, 5'd16);
      rst = 1'b0;
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd14, 5'd16);

      // Random traffic over a small address range so hazards collide often
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         step($urandom_range(0, 7) != 0, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom), 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      rst = 1'b0;
      repeat (4) idle(5'd1, 5'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
